// File: rtl/kbd_mode_ctrl_if.sv
// Decoded PS/2 key-event bus from the keyboard receiver into kbd_mode_ctrl.
interface kbd_mode_ctrl_if;
    logic       key_event;
    logic [7:0] scancode;
    logic       released;
    logic       extended;

    modport master (output key_event, scancode, released, extended);
    modport slave  (input  key_event, scancode, released, extended);
endinterface

// File: rtl/kbd_mode_ctrl.sv
// Keyboard command decoder: make/release-paired key events select sticky modes or fire timed strobes.
// Define KBD_MODE_CTRL_EXTENDED_EN to decode E0-prefixed keys; otherwise they are discarded.
module kbd_mode_ctrl #(
    parameter int unsigned NUM_MODES   = 4,
    parameter int unsigned NUM_STROBES = 5,
    parameter int unsigned PULSE_LEN   = 1,
    parameter int unsigned RESET_MODE  = 0,
    parameter logic [NUM_MODES*18-1:0] MODE_CODES = {
        9'h06B, 9'h025, 9'h07A, 9'h026, 9'h072, 9'h01E, 9'h069, 9'h016},
    parameter logic [NUM_STROBES*18-1:0] STROBE_CODES = {
        9'h175, 9'h04E, 9'h07D, 9'h046, 9'h075, 9'h03E, 9'h06C, 9'h03D, 9'h073, 9'h02E}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    kbd_mode_ctrl_if.slave               key_if,
    output logic [$clog2(NUM_MODES)-1:0] mode,
    output logic [NUM_MODES-1:0]         mode_oh,
    output logic                         mode_changed,
    output logic [NUM_STROBES-1:0]       strobe,
    output logic                         busy
);

    localparam int unsigned ModeW = $clog2(NUM_MODES);
    localparam int unsigned StrW  = (NUM_STROBES > 1) ? $clog2(NUM_STROBES) : 1;
    localparam int unsigned IdxW  = (ModeW > StrW) ? ModeW : StrW;

    typedef struct packed {
        logic            hit;
        logic            is_mode;
        logic [IdxW-1:0] idx;
    } lookup_t;

    typedef enum logic [0:0] {StIdle, StArmed} state_e;

    // Strobe table scanned first and mode table last so a mode entry overrides; descending
    // loops make the lowest index win among duplicates.
    function automatic lookup_t lookup(input logic [8:0] code);
        lookup_t r;
        r = '0;
        for (int i = int'(NUM_STROBES) - 1; i >= 0; i--) begin
            if (STROBE_CODES[i*18 +: 9] == code || STROBE_CODES[i*18+9 +: 9] == code) begin
                r.hit     = 1'b1;
                r.is_mode = 1'b0;
                r.idx     = IdxW'(i);
            end
        end
        for (int i = int'(NUM_MODES) - 1; i >= 0; i--) begin
            if (MODE_CODES[i*18 +: 9] == code || MODE_CODES[i*18+9 +: 9] == code) begin
                r.hit     = 1'b1;
                r.is_mode = 1'b1;
                r.idx     = IdxW'(i);
            end
        end
        return r;
    endfunction

    function automatic logic code_hit(input logic [8:0] code);
        logic h;
        h = 1'b0;
        for (int i = 0; i < int'(NUM_MODES) * 2; i++) begin
            if (MODE_CODES[i*9 +: 9] == code) h = 1'b1;
        end
        for (int i = 0; i < int'(NUM_STROBES) * 2; i++) begin
            if (STROBE_CODES[i*9 +: 9] == code) h = 1'b1;
        end
        return h;
    endfunction

    state_e      state_q, state_d;
    logic [8:0]  pend_q, pend_d;
    logic        live_q;
    logic        ev_valid;
    logic [8:0]  ev_code;
    logic        ev_hit;
    lookup_t     pend_lk;
    logic        exec;
    logic        mode_we;
    logic [NUM_STROBES-1:0] fire;

    logic [ModeW-1:0]       mode_q, mode_d;
    logic [NUM_MODES-1:0]   mode_oh_q, mode_oh_d;
    logic                   chg_q, chg_d;
    logic [15:0]            cnt_q [NUM_STROBES];
    logic [15:0]            cnt_d [NUM_STROBES];
    logic [NUM_STROBES-1:0] strobe_q, strobe_d;
    logic                   busy_q, busy_d;

`ifdef KBD_MODE_CTRL_EXTENDED_EN
    assign ev_valid = key_if.key_event & live_q;
    assign ev_code  = {key_if.extended, key_if.scancode};
`else
    assign ev_valid = key_if.key_event & ~key_if.extended & live_q;
    assign ev_code  = {1'b0, key_if.scancode};
`endif

    assign ev_hit  = code_hit(ev_code);
    assign pend_lk = lookup(pend_q);

    // live_q masks the event that coincides with the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pend_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                if (ev_valid && !key_if.released && ev_hit) begin
                    state_d = StArmed;
                    pend_d  = ev_code;
                end
            end
            StArmed: begin
                if (ev_valid) begin
                    if (!key_if.released) begin
                        if (ev_code != pend_q) begin
                            if (ev_hit) begin
                                pend_d = ev_code;
                            end else begin
                                state_d = StIdle;
                                pend_d  = '0;
                            end
                        end
                    end else if (ev_code == pend_q) begin
                        state_d = StIdle;
                        pend_d  = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                pend_d  = '0;
            end
        endcase
    end

    always_comb begin
        exec    = (state_q == StArmed) && ev_valid && key_if.released &&
                  (ev_code == pend_q) && pend_lk.hit;
        mode_we = exec && pend_lk.is_mode;
        fire    = '0;
        for (int j = 0; j < int'(NUM_STROBES); j++) begin
            if (exec && !pend_lk.is_mode && pend_lk.idx == IdxW'(j)) fire[j] = 1'b1;
        end
    end

    always_comb begin
        mode_d = mode_q;
        chg_d  = 1'b0;
        if (mode_we) begin
            mode_d = pend_lk.idx[ModeW-1:0];
            chg_d  = (pend_lk.idx[ModeW-1:0] != mode_q);
        end
        mode_oh_d = '0;
        for (int i = 0; i < int'(NUM_MODES); i++) begin
            mode_oh_d[i] = (mode_d == ModeW'(i));
        end
    end

    // Retrigger reloads the counter, so a live pulse is stretched without a low gap.
    always_comb begin
        for (int j = 0; j < int'(NUM_STROBES); j++) begin
            cnt_d[j] = cnt_q[j];
            if (fire[j]) begin
                cnt_d[j] = 16'(PULSE_LEN);
            end else if (cnt_q[j] != 16'd0) begin
                cnt_d[j] = cnt_q[j] - 16'd1;
            end
            strobe_d[j] = (cnt_d[j] != 16'd0);
        end
        busy_d = |strobe_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= ModeW'(RESET_MODE);
            mode_oh_q <= NUM_MODES'(1) << RESET_MODE;
            chg_q     <= 1'b0;
            strobe_q  <= '0;
            busy_q    <= 1'b0;
            for (int j = 0; j < int'(NUM_STROBES); j++) cnt_q[j] <= '0;
        end else begin
            mode_q    <= mode_d;
            mode_oh_q <= mode_oh_d;
            chg_q     <= chg_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            for (int j = 0; j < int'(NUM_STROBES); j++) cnt_q[j] <= cnt_d[j];
        end
    end

    assign mode         = mode_q;
    assign mode_oh      = mode_oh_q;
    assign mode_changed = chg_q;
    assign strobe       = strobe_q;
    assign busy         = busy_q;

endmodule
